// File: rtl/wb_sb_pkg.sv
// Shared types and width helpers for the writeback scoreboard.
package wb_sb_pkg;

  localparam int unsigned SbXlen  = 32;
  localparam int unsigned SbRegAw = 5;

  typedef enum logic [1:0] {
    SbIdle,
    SbRun,
    SbDone
  } sb_state_t;

  typedef struct packed {
    logic [SbRegAw-1:0] rd;
    logic [SbXlen-1:0]  val;
  } sb_entry_t;

  function automatic int unsigned sb_idx_w(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold the value n itself, not just n-1.
  function automatic int unsigned sb_cnt_w(int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/wb_sb_table.sv
// Expected-writeback table: register array, synchronous write, combinational read.
module wb_sb_table
  import wb_sb_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  localparam int unsigned IdxW = sb_idx_w(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IdxW-1:0] waddr,
  input  sb_entry_t       wdata,
  input  logic [IdxW-1:0] raddr,
  output sb_entry_t       rdata
);

  sb_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback scoreboard: checks accepted register-file writes, in order, against
// the expected table and reports pass/fail, mismatch count, first failure and timeout.
module wb_scoreboard
  import wb_sb_pkg::*;
#(
  parameter int unsigned XLEN         = SbXlen,
  parameter int unsigned REG_AW       = SbRegAw,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned STOP_ON_FAIL = 0,
  localparam int unsigned IdxW = sb_idx_w(DEPTH),
  localparam int unsigned CntW = IdxW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tbl_we,
  input  logic [IdxW-1:0]   tbl_idx,
  input  logic [REG_AW-1:0] tbl_rd,
  input  logic [XLEN-1:0]   tbl_val,
  input  logic [CntW-1:0]   cfg_len,
  input  logic              start,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CntW-1:0]   fail_cnt,
  output logic [IdxW-1:0]   first_idx,
  output logic [XLEN-1:0]   first_exp,
  output logic [XLEN-1:0]   first_got,
  output logic [REG_AW-1:0] first_rd_got
);

  localparam int unsigned WdW        = sb_cnt_w(TIMEOUT);
  localparam bit          StopOnFail = (STOP_ON_FAIL != 0);

  sb_state_t         state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   len_q, len_d;
  logic [WdW-1:0]    wdog_q, wdog_d;
  logic [CntW-1:0]   fail_cnt_q, fail_cnt_d;
  logic              timeout_q, timeout_d;
  logic              pass_q, pass_d;
  logic [IdxW-1:0]   first_idx_q, first_idx_d;
  logic [XLEN-1:0]   first_exp_q, first_exp_d;
  logic [XLEN-1:0]   first_got_q, first_got_d;
  logic [REG_AW-1:0] first_rd_q, first_rd_d;

  sb_entry_t wr_entry, exp_entry;
  logic      len_ok, start_ok, evt, mismatch, last, finish, expire;

  assign wr_entry.rd  = tbl_rd;
  assign wr_entry.val = tbl_val;

  wb_sb_table #(
    .DEPTH(DEPTH)
  ) u_table (
    .clk  (clk),
    .we   (tbl_we && (state_q != SbRun)),
    .waddr(tbl_idx),
    .wdata(wr_entry),
    .raddr(ptr_q),
    .rdata(exp_entry)
  );

  assign len_ok   = (cfg_len != '0) && (cfg_len <= CntW'(DEPTH));
  assign start_ok = start && len_ok && (state_q != SbRun);
  // x0 writes never count as events, so they cannot feed the watchdog either.
  assign evt      = (state_q == SbRun) && wb_valid && (wb_rd != '0);
  assign mismatch = (wb_rd != exp_entry.rd) || (wb_data != exp_entry.val);
  // Length is latched at start so a changing cfg_len cannot disturb a live run.
  assign last     = ({1'b0, ptr_q} == (len_q - CntW'(1)));
  assign finish   = evt && (last || (StopOnFail && mismatch));
  assign expire   = (state_q == SbRun) && !evt && (wdog_q == WdW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SbIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SbIdle, SbDone: if (start_ok) state_d = SbRun;
      SbRun:          if (finish || expire) state_d = SbDone;
      default:        state_d = SbIdle;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    len_d       = len_q;
    wdog_d      = wdog_q;
    fail_cnt_d  = fail_cnt_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;
    first_idx_d = first_idx_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    first_rd_d  = first_rd_q;
    if (start_ok) begin
      ptr_d       = '0;
      len_d       = cfg_len;
      wdog_d      = '0;
      fail_cnt_d  = '0;
      timeout_d   = 1'b0;
      pass_d      = 1'b0;
      first_idx_d = '0;
      first_exp_d = '0;
      first_got_d = '0;
      first_rd_d  = '0;
    end else if (evt) begin
      wdog_d = '0;
      if (!finish) ptr_d = ptr_q + IdxW'(1);
      if (mismatch) begin
        if (fail_cnt_q != CntW'(DEPTH)) fail_cnt_d = fail_cnt_q + CntW'(1);
        if (fail_cnt_q == '0) begin
          first_idx_d = ptr_q;
          first_exp_d = exp_entry.val;
          first_got_d = wb_data;
          first_rd_d  = wb_rd;
        end
      end
      if (finish) pass_d = !mismatch && (fail_cnt_q == '0);
    end else if (state_q == SbRun) begin
      if (expire) begin
        timeout_d = 1'b1;
        pass_d    = 1'b0;
      end else begin
        wdog_d = wdog_q + WdW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      len_q       <= '0;
      wdog_q      <= '0;
      fail_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      first_idx_q <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
      first_rd_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      wdog_q      <= wdog_d;
      fail_cnt_q  <= fail_cnt_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
      first_idx_q <= first_idx_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
      first_rd_q  <= first_rd_d;
    end
  end

  always_comb begin
    busy         = (state_q == SbRun);
    done         = (state_q == SbDone);
    pass         = pass_q;
    timeout      = timeout_q;
    fail_cnt     = fail_cnt_q;
    first_idx    = first_idx_q;
    first_exp    = first_exp_q;
    first_got    = first_got_q;
    first_rd_got = first_rd_q;
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: one run-to-completion DUT and one stop-on-fail DUT
// share the same stimulus.
module tb_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tbl_we = 1'b0;
  logic [4:0]  tbl_idx = '0;
  logic [4:0]  tbl_rd = '0;
  logic [31:0] tbl_val = '0;
  logic [5:0]  cfg_len = '0;
  logic        start = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;

  logic        busy, done, pass, timeout;
  logic [5:0]  fail_cnt;
  logic [4:0]  first_idx, first_rd_got;
  logic [31:0] first_exp, first_got;

  logic        s_busy, s_done, s_pass, s_timeout;
  logic [5:0]  s_fail_cnt;
  logic [4:0]  s_first_idx, s_first_rd_got;
  logic [31:0] s_first_exp, s_first_got;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_scoreboard #(
    .XLEN(32), .REG_AW(5), .DEPTH(32), .TIMEOUT(8), .STOP_ON_FAIL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_rd(tbl_rd),
    .tbl_val(tbl_val), .cfg_len(cfg_len), .start(start), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .fail_cnt(fail_cnt), .first_idx(first_idx), .first_exp(first_exp),
    .first_got(first_got), .first_rd_got(first_rd_got)
  );

  wb_scoreboard #(
    .XLEN(32), .REG_AW(5), .DEPTH(32), .TIMEOUT(8), .STOP_ON_FAIL(1)
  ) dut_sof (
    .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_rd(tbl_rd),
    .tbl_val(tbl_val), .cfg_len(cfg_len), .start(start), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(s_busy), .done(s_done), .pass(s_pass),
    .timeout(s_timeout), .fail_cnt(s_fail_cnt), .first_idx(s_first_idx),
    .first_exp(s_first_exp), .first_got(s_first_got), .first_rd_got(s_first_rd_got)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_entry(input logic [4:0] idx, input logic [4:0] rd,
                             input logic [31:0] val);
    tbl_we = 1'b1; tbl_idx = idx; tbl_rd = rd; tbl_val = val;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic start_run(input logic [5:0] len);
    cfg_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1; wb_rd = rd; wb_data = data;
    tick();
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%0b exp=0", pass); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
    checks++; if (fail_cnt !== 6'd0) begin failures++; $display("FAIL reset_fail_cnt got=%0d exp=0", fail_cnt); end
    checks++; if ({first_idx, first_exp, first_got, first_rd_got} !== 74'd0) begin
      failures++; $display("FAIL reset_first got=%0h/%0h/%0h/%0h exp=0", first_idx, first_exp, first_got, first_rd_got);
    end
  endtask

  task automatic load_basic();
    write_entry(5'd0, 5'd1, 32'd100);
    write_entry(5'd1, 5'd2, 32'd100);
    write_entry(5'd2, 5'd30, 32'd12);
  endtask

  task automatic test_pass();
    load_basic();
    start_run(6'd3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pass_busy_start got=%0b exp=1", busy); end
    send_wb(5'd1, 32'd100);
    idle(4);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pass_busy_stall got=%0b exp=1", busy); end
    send_wb(5'd2, 32'd100);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL pass_done_early got=%0b exp=0", done); end
    send_wb(5'd30, 32'd12);
    checks++; if ({busy, done, pass} !== 3'b011) begin
      failures++; $display("FAIL pass_end busy/done/pass got=%b exp=011", {busy, done, pass});
    end
    checks++; if (fail_cnt !== 6'd0) begin failures++; $display("FAIL pass_fail_cnt got=%0d exp=0", fail_cnt); end
  endtask

  task automatic test_mismatch();
    start_run(6'd3);
    send_wb(5'd1, 32'd100);
    send_wb(5'd2, 32'd50);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mm_busy_after_miss got=%0b exp=1", busy); end
    send_wb(5'd30, 32'd12);
    checks++; if ({done, pass} !== 2'b10) begin
      failures++; $display("FAIL mm_done_pass got=%b exp=10", {done, pass});
    end
    checks++; if (fail_cnt !== 6'd1) begin failures++; $display("FAIL mm_fail_cnt got=%0d exp=1", fail_cnt); end
    checks++; if (first_idx !== 5'd1) begin failures++; $display("FAIL mm_first_idx got=%0d exp=1", first_idx); end
    checks++; if (first_exp !== 32'd100) begin failures++; $display("FAIL mm_first_exp got=%0d exp=100", first_exp); end
    checks++; if (first_got !== 32'd50) begin failures++; $display("FAIL mm_first_got got=%0d exp=50", first_got); end
    checks++; if (first_rd_got !== 5'd2) begin failures++; $display("FAIL mm_first_rd got=%0d exp=2", first_rd_got); end
  endtask

  task automatic test_stop_on_fail();
    write_entry(5'd0, 5'd11, 32'hDEADBEEF);
    write_entry(5'd1, 5'd12, 32'hFFFFFFEF);
    start_run(6'd2);
    send_wb(5'd13, 32'hDEADBEEF);
    checks++; if ({s_busy, s_done, s_pass} !== 3'b010) begin
      failures++; $display("FAIL sof_end busy/done/pass got=%b exp=010", {s_busy, s_done, s_pass});
    end
    checks++; if (s_fail_cnt !== 6'd1) begin failures++; $display("FAIL sof_fail_cnt got=%0d exp=1", s_fail_cnt); end
    checks++; if (s_first_rd_got !== 5'd13) begin failures++; $display("FAIL sof_first_rd got=%0d exp=13", s_first_rd_got); end
    checks++; if (s_first_exp !== 32'hDEADBEEF) begin failures++; $display("FAIL sof_first_exp got=%0h exp=deadbeef", s_first_exp); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sof_nostop_busy got=%0b exp=1", busy); end
    send_wb(5'd12, 32'hFFFFFFEF);
    checks++; if (s_fail_cnt !== 6'd1) begin failures++; $display("FAIL sof_second_uncompared got=%0d exp=1", s_fail_cnt); end
    checks++; if ({done, pass, fail_cnt} !== {2'b10, 6'd1}) begin
      failures++; $display("FAIL nostop_end done/pass/cnt got=%b/%0d exp=10/1", {done, pass}, fail_cnt);
    end
  endtask

  task automatic test_timeout();
    write_entry(5'd0, 5'd5, 32'd7);
    write_entry(5'd1, 5'd6, 32'd8);
    start_run(6'd2);
    send_wb(5'd5, 32'd7);
    for (int k = 1; k <= 8; k++) begin
      wb_valid = (k % 2) == 1; wb_rd = 5'd0; wb_data = 32'd8;
      tick();
      if (k == 7) begin
        checks++; if ({busy, timeout} !== 2'b10) begin
          failures++; $display("FAIL to_early busy/timeout got=%b exp=10", {busy, timeout});
        end
      end
    end
    wb_valid = 1'b0;
    checks++; if ({done, pass, timeout} !== 3'b101) begin
      failures++; $display("FAIL to_end done/pass/timeout got=%b exp=101", {done, pass, timeout});
    end
  endtask

  task automatic test_wdog_edge();
    write_entry(5'd2, 5'd7, 32'd9);
    start_run(6'd3);
    send_wb(5'd5, 32'd7);
    idle(7);
    send_wb(5'd6, 32'd8);
    checks++; if ({busy, timeout} !== 2'b10) begin
      failures++; $display("FAIL wd_edge busy/timeout got=%b exp=10", {busy, timeout});
    end
    send_wb(5'd7, 32'd9);
    checks++; if ({done, pass, timeout, fail_cnt} !== {3'b110, 6'd0}) begin
      failures++; $display("FAIL wd_end done/pass/to/cnt got=%b/%0d exp=110/0", {done, pass, timeout}, fail_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    start_run(6'd3);
    send_wb(5'd5, 32'd7);
    write_entry(5'd1, 5'd6, 32'h1234);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if ({busy, done, pass, timeout, fail_cnt} !== 10'd0) begin
      failures++; $display("FAIL rst_mid outputs got=%b/%0d exp=0", {busy, done, pass, timeout}, fail_cnt);
    end
    start_run(6'd0);
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL len0_ignored got=%b exp=00", {busy, done}); end
    start_run(6'd33);
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL len33_ignored got=%b exp=00", {busy, done}); end
    start_run(6'd2);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rerun_busy got=%0b exp=1", busy); end
    send_wb(5'd5, 32'd7);
    send_wb(5'd6, 32'd8);
    checks++; if ({done, pass, fail_cnt} !== {2'b11, 6'd0}) begin
      failures++; $display("FAIL rerun_end done/pass/cnt got=%b/%0d exp=11/0", {done, pass}, fail_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_stop_on_fail();
    test_timeout();
    test_wdog_edge();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
